trig_ratio_div: RTL

TRIG_RATIO_DIV -- requirements
Module: trig_ratio_div

---
 rtl/trig_pkg.sv | 25 ++
 rtl/trig_div_core.sv | 88 ++++++++
 rtl/trig_ratio_div.sv | 137 +++++++++++++
 3 files changed

// File: rtl/trig_pkg.sv
// ============================================================================
// Module      : trig_pkg
// Description : Constants and FSM state encoding shared by the trig stages
//               (Sin/Cos/Tan/Cot) and the ratio divider.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package trig_pkg;

  // Fixed-point scale of every trig stage output (ratio scaled by 10^4)
  localparam int TRIG_SCALE = 10000;
  // Operand / result width of the trig stages
  localparam int TRIG_W     = 16;

  // Handshake FSM states of the ratio divider
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    DONE = 2'd2
  } trig_state_e;

endpackage : trig_pkg

`default_nettype wire

// File: rtl/trig_div_core.sv
// ============================================================================
// Module      : trig_div_core
// Description : Iterative restoring divider, one quotient bit per cycle.
//               A 2W-bit dividend is divided by a W-bit divisor in exactly
//               2W cycles after the start pulse.
// Ports       : clk, rst        - clock, synchronous active-high reset
//               i_start         - load operands and begin (ignored if busy)
//               i_dividend      - 2W-bit dividend
//               i_divisor       - W-bit divisor (must be non-zero)
//               o_busy          - iterations in progress
//               o_done          - one-cycle pulse, o_quotient valid
//               o_quotient      - 2W-bit quotient
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module trig_div_core #(
  parameter int W = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           i_start,
  input  logic [2*W-1:0] i_dividend,
  input  logic [W-1:0]   i_divisor,
  output logic           o_busy,
  output logic           o_done,
  output logic [2*W-1:0] o_quotient
);

  localparam int            C_CNT_W = $clog2(2 * W);
  localparam logic [C_CNT_W-1:0] C_LAST = C_CNT_W'(2 * W - 1);

  logic [2*W-1:0]     r_dvd;    // dividend shifts out MSB-first, quotient shifts in
  logic [W-1:0]       r_div;
  logic [W-1:0]       r_rem;
  logic [C_CNT_W-1:0] r_count;
  logic               r_busy;
  logic               r_done;

  logic [W:0] w_shift;
  logic [W:0] w_trial;
  logic       w_qbit;
  logic [W-1:0] w_rem_next;
  logic       w_unused_trial_msb;

  // Remainder is always below the divisor, so the shifted value fits W+1
  // bits and a successful trial subtraction fits back into W bits.
  assign w_shift    = {r_rem, r_dvd[2*W-1]};
  assign w_trial    = w_shift - {1'b0, r_div};
  assign w_qbit     = (w_shift >= {1'b0, r_div});
  assign w_rem_next = w_qbit ? w_trial[W-1:0] : w_shift[W-1:0];
  assign w_unused_trial_msb = w_trial[W];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_dvd   <= '0;
      r_div   <= '0;
      r_rem   <= '0;
      r_count <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_start && !r_busy) begin
        r_dvd   <= i_dividend;
        r_div   <= i_divisor;
        r_rem   <= '0;
        r_count <= '0;
        r_busy  <= 1'b1;
      end else if (r_busy) begin
        r_dvd   <= {r_dvd[2*W-2:0], w_qbit};
        r_rem   <= w_rem_next;
        r_count <= r_count + 1'b1;
        if (r_count == C_LAST) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_quotient = r_dvd;

endmodule : trig_div_core

`default_nettype wire

// File: rtl/trig_ratio_div.sv
// ============================================================================
// Module      : trig_ratio_div
// Description : Valid/ready wrapper computing quot = floor(num*SCALE/den)
//               with divide-by-zero and overflow flags.
//               Optional macro TRIG_DIV_SAT_EN: saturate quot to all-ones on
//               overflow (otherwise the low W quotient bits are returned).
// Ports       : clk, rst              - clock, synchronous active-high reset
//               in_valid/in_ready     - operand handshake (ready only in IDLE)
//               num, den              - unsigned numerator / denominator
//               out_valid/out_ready   - result handshake
//               quot, dz, ovf         - quotient, divide-by-zero, overflow
// Latency     : 33 cycles (den!=0), 1 cycle (den==0) from transfer edge.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module trig_ratio_div
  import trig_pkg::*;
#(
  parameter int SCALE = TRIG_SCALE,
  parameter int W     = TRIG_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] num,
  input  logic [W-1:0] den,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] quot,
  output logic         dz,
  output logic         ovf
);

  trig_state_e r_state;
  logic        r_in_ready;
  logic        r_out_valid;
  logic [W-1:0] r_quot;
  logic        r_dz;
  logic        r_ovf;
  logic        r_dz_pend;   // den==0 captured at transfer, resolves next edge

  logic           w_xfer;
  logic           w_start;
  logic [2*W-1:0] w_dividend;
  logic           w_core_busy;
  logic           w_core_done;
  logic [2*W-1:0] w_core_quot;
  logic           w_ovf;
  logic [W-1:0]   w_quot_sel;

  assign w_xfer     = in_valid && r_in_ready;
  assign w_start    = w_xfer && (den != '0);
  // Full 2W-bit product, no truncation of the scaled numerator
  assign w_dividend = (2*W)'(num) * (2*W)'(SCALE);

  trig_div_core #(
    .W (W)
  ) u_core (
    .clk        (clk),
    .rst        (rst),
    .i_start    (w_start),
    .i_dividend (w_dividend),
    .i_divisor  (den),
    .o_busy     (w_core_busy),
    .o_done     (w_core_done),
    .o_quotient (w_core_quot)
  );

  assign w_ovf = |w_core_quot[2*W-1:W];

`ifdef TRIG_DIV_SAT_EN
  assign w_quot_sel = w_ovf ? {W{1'b1}} : w_core_quot[W-1:0];
`else
  assign w_quot_sel = w_core_quot[W-1:0];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_quot      <= '0;
      r_dz        <= 1'b0;
      r_ovf       <= 1'b0;
      r_dz_pend   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_xfer) begin
            r_dz_pend  <= (den == '0);
            r_in_ready <= 1'b0;
            r_state    <= DIV;
          end
        end
        DIV: begin
          if (r_dz_pend) begin
            r_quot      <= {W{1'b1}};
            r_dz        <= 1'b1;
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end else if (w_core_done && !w_core_busy) begin
            r_quot      <= w_quot_sel;
            r_dz        <= 1'b0;
            r_ovf       <= w_ovf;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_dz_pend   <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign quot      = r_quot;
  assign dz        = r_dz;
  assign ovf       = r_ovf;

endmodule : trig_ratio_div

`default_nettype wire
